parking_stats: RTL and testbench
================================

PARKING_STATS -- requirements
Module: parking_stats

Interface
REQ-001 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high; asserting it SHALL force all state to reset values immediately, with no clock edge required.
REQ-003 hourAdvance  input  1  one-cycle pulse, driven by the keypress confirm of the control stage; advances the working hour.
REQ-004 carEnter  input  1  level input, driven by the enter-gate-open signal; may stay high for multiple cycles.
REQ-005 carExit  input  1  level input, driven by the exit-gate-open signal; may stay high for multiple cycles.
REQ-006 rushStart  input  1  one-cycle pulse marking the start of a rush hour.
REQ-007 rushEnd  input  1  one-cycle pulse marking the end of a rush hour.
REQ-008 rdAddr  input  3  hour index for the entry-count read port.
REQ-009 hour  output  3  current working hour, 0..7.
REQ-010 dayDone  output  1  high once hour 7 has been passed.
REQ-011 occupancy  output  2  cars currently in the lot, 0..3.
REQ-012 rushStartHour, rushEndHour  output  3 each  captured hours.
REQ-013 rushStartValid, rushEndValid  output  1 each  capture flags.
REQ-014 rdData  output  4  entry count for hour rdAddr, registered.

Function
REQ-015 An enter event SHALL be the rising edge of carEnter (0 in the previous cycle, 1 now); an exit event SHALL be defined the same way from carExit.
REQ-016 An enter event SHALL increment occupancy, saturating at 3; an exit event SHALL decrement occupancy, saturating at 0.
REQ-017 Enter and exit events in the same cycle SHALL leave occupancy unchanged.
REQ-018 The block SHALL hold eight 4-bit entry counters, entries[0..7]; an enter event in state COUNTING SHALL increment entries[hour], saturating at 15.
REQ-019 An enter event coincident with hourAdvance SHALL be credited to the pre-advance hour.
REQ-020 The FSM SHALL have two states, COUNTING and DONE; reset SHALL place it in COUNTING with hour=0.
REQ-021 In COUNTING, hourAdvance with hour<7 SHALL increment hour.
REQ-022 In COUNTING, hourAdvance with hour==7 SHALL transition to DONE; hour SHALL hold at 7 and dayDone SHALL assert.
REQ-023 DONE SHALL persist until reset; in DONE, hourAdvance SHALL be ignored.
REQ-024 In DONE, entry counters and rush captures SHALL freeze; occupancy SHALL continue to track events.
REQ-025 In COUNTING, the first rushStart SHALL load rushStartHour=hour and set rushStartValid; later rushStart pulses SHALL be ignored.
REQ-026 rushEnd SHALL be captured (rushEndHour=hour, rushEndValid set) only when rushStartValid is already 1 and rushEndValid is 0.
REQ-027 A rushEnd in the same cycle as the capturing rushStart SHALL be ignored.
REQ-028 rdData SHALL present entries[rdAddr] one cycle after rdAddr is sampled.
REQ-029 When a read and an increment hit the same counter in the same cycle, rdData SHALL return the pre-increment value.
REQ-030 All outputs SHALL be register-driven; the edge-detect history is internal.

Reset
REQ-031 On reset: hour=0, dayDone=0, occupancy=0, all entries=0, rushStartHour=rushEndHour=0, both valid flags=0, rdData=0, edge-detect history=0, FSM=COUNTING.
REQ-032 Reset asserted mid-day SHALL discard all counts, and the first cycle after release SHALL behave as power-up.
REQ-033 A carEnter level held high across reset release SHALL produce one enter event on the first clock edge after release.

Structure
REQ-034 The shared package parking_pkg SHALL define NUM_HOURS=8, MAX_OCC=3, CNT_W=4, HOUR_W=3 and the stats_state_t enum {COUNTING, DONE}.
REQ-035 Rising-edge detection SHALL be implemented in sub-module edge_detect (clk, reset, in, pulse), instantiated once each for carEnter and carExit.

Verification
REQ-036 Scenario 1: reset, then carEnter held high for 3 cycles -> exactly one enter event; occupancy=1; entries[0]=1.
REQ-037 Scenario 2: 4 enter events, then 5 exit events -> occupancy saturates at 3, then reaches 0 and stays at 0.
REQ-038 Scenario 3: enter event and hourAdvance in the same cycle at hour=2 -> entries[2] increments, entries[3] is unchanged, hour=3; rdAddr=2 gives rdData correct one cycle later.
REQ-039 Scenario 4: rushStart at hour 1, rushStart at hour 2, rushEnd at hour 4 -> rushStartHour=1, rushEndHour=4, both valid flags=1.
REQ-040 Scenario 5: 8 hourAdvance pulses -> hour=7, dayDone=1; a following enter event leaves every entries counter unchanged but sets occupancy to 1.
REQ-041 Scenario 6: reset asserted between clock edges mid-count -> all outputs are 0 before the next edge.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared widths, limits and the day-tracking state type for the parking statistics block.
package parking_pkg;

    localparam int NUM_HOURS = 8;
    localparam int MAX_OCC   = 3;
    localparam int CNT_W     = 4;
    localparam int HOUR_W    = 3;
    localparam int OCC_W     = 2;

    typedef enum logic {
        COUNTING = 1'b0,
        DONE     = 1'b1
    } stats_state_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: pulse is high in the cycle where in is 1 and was 0 on the previous edge.
// History resets to 0, so a level already high at reset release yields one pulse.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = in & ~prev_q;

endmodule

// File: rtl/parking_stats.sv
// Parking lot statistics: occupancy, per-hour entry counts, rush-hour capture and a registered count read port.
// All outputs come straight from flops; counts and captures freeze once the day is done.
module parking_stats
    import parking_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              hourAdvance,
    input  logic              carEnter,
    input  logic              carExit,
    input  logic              rushStart,
    input  logic              rushEnd,
    input  logic [HOUR_W-1:0] rdAddr,
    output logic [HOUR_W-1:0] hour,
    output logic              dayDone,
    output logic [OCC_W-1:0]  occupancy,
    output logic [HOUR_W-1:0] rushStartHour,
    output logic [HOUR_W-1:0] rushEndHour,
    output logic              rushStartValid,
    output logic              rushEndValid,
    output logic [CNT_W-1:0]  rdData
);

    logic enter_evt;
    logic exit_evt;

    edge_detect u_enter_edge (.clk(clk), .reset(reset), .in(carEnter), .pulse(enter_evt));
    edge_detect u_exit_edge  (.clk(clk), .reset(reset), .in(carExit),  .pulse(exit_evt));

    stats_state_t      state_q, state_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic              day_done_q, day_done_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  entries_q [NUM_HOURS];
    logic [CNT_W-1:0]  entries_d [NUM_HOURS];
    logic [HOUR_W-1:0] rs_hour_q, rs_hour_d;
    logic [HOUR_W-1:0] re_hour_q, re_hour_d;
    logic              rs_vld_q, rs_vld_d;
    logic              re_vld_q, re_vld_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;

    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        day_done_d = day_done_q;
        occ_d      = occ_q;
        entries_d  = entries_q;
        rs_hour_d  = rs_hour_q;
        re_hour_d  = re_hour_q;
        rs_vld_d   = rs_vld_q;
        re_vld_d   = re_vld_q;
        // Read the pre-update array so a same-cycle increment is not visible yet.
        rd_data_d  = entries_q[rdAddr];

        if (enter_evt && !exit_evt && occ_q != OCC_W'(MAX_OCC)) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (exit_evt && !enter_evt && occ_q != '0) begin
            occ_d = occ_q - OCC_W'(1);
        end

        if (state_q == COUNTING) begin
            // Credit uses hour_q, so an entry coincident with the advance lands in the old hour.
            if (enter_evt) begin
                entries_d[hour_q] = sat_inc_cnt(entries_q[hour_q]);
            end
            if (hourAdvance) begin
                if (hour_q == HOUR_W'(NUM_HOURS - 1)) begin
                    state_d    = DONE;
                    day_done_d = 1'b1;
                end else begin
                    hour_d = hour_q + HOUR_W'(1);
                end
            end
            if (rushStart && !rs_vld_q) begin
                rs_hour_d = hour_q;
                rs_vld_d  = 1'b1;
            end
            if (rushEnd && rs_vld_q && !re_vld_q) begin
                re_hour_d = hour_q;
                re_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= COUNTING;
            hour_q     <= '0;
            day_done_q <= 1'b0;
            occ_q      <= '0;
            for (int i = 0; i < NUM_HOURS; i++) begin
                entries_q[i] <= '0;
            end
            rs_hour_q  <= '0;
            re_hour_q  <= '0;
            rs_vld_q   <= 1'b0;
            re_vld_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            day_done_q <= day_done_d;
            occ_q      <= occ_d;
            entries_q  <= entries_d;
            rs_hour_q  <= rs_hour_d;
            re_hour_q  <= re_hour_d;
            rs_vld_q   <= rs_vld_d;
            re_vld_q   <= re_vld_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign hour           = hour_q;
    assign dayDone        = day_done_q;
    assign occupancy      = occ_q;
    assign rushStartHour  = rs_hour_q;
    assign rushEndHour    = re_hour_q;
    assign rushStartValid = rs_vld_q;
    assign rushEndValid   = re_vld_q;
    assign rdData         = rd_data_q;

endmodule

// File: tb/tb_parking_stats.sv
// Directed bench: cycle-by-cycle vector table for the counting day, then hand sequences for reset and end-of-day corners.
module tb_parking_stats;

    logic       clk;
    logic       reset;
    logic       hourAdvance, carEnter, carExit, rushStart, rushEnd;
    logic [2:0] rdAddr;
    logic [2:0] hour;
    logic       dayDone;
    logic [1:0] occupancy;
    logic [2:0] rushStartHour, rushEndHour;
    logic       rushStartValid, rushEndValid;
    logic [3:0] rdData;

    int checks   = 0;
    int failures = 0;

    parking_stats dut (
        .clk(clk), .reset(reset),
        .hourAdvance(hourAdvance), .carEnter(carEnter), .carExit(carExit),
        .rushStart(rushStart), .rushEnd(rushEnd), .rdAddr(rdAddr),
        .hour(hour), .dayDone(dayDone), .occupancy(occupancy),
        .rushStartHour(rushStartHour), .rushEndHour(rushEndHour),
        .rushStartValid(rushStartValid), .rushEndValid(rushEndValid),
        .rdData(rdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       hadv, ent, ext, rs, re;
        logic [2:0] addr;
        logic [2:0] h;
        logic       d;
        logic [1:0] occ;
        logic [2:0] rsh;
        logic       rsv;
        logic [2:0] reh;
        logic       rev;
        logic [3:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic hadv, logic ent, logic ext, logic rs, logic re, int addr,
                                int h, logic d, int occ, int rsh, logic rsv, int reh, logic rev, int rd);
        vec_t v;
        v.hadv = hadv; v.ent = ent; v.ext = ext; v.rs = rs; v.re = re;
        v.addr = 3'(addr); v.h = 3'(h); v.d = d; v.occ = 2'(occ);
        v.rsh = 3'(rsh); v.rsv = rsv; v.reh = 3'(reh); v.rev = rev; v.rd = 4'(rd);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int h, input logic d, input int occ, input int rsh,
                           input logic rsv, input int reh, input logic rev, input int rd);
        chk({tag, " hour"},      32'(hour),           32'(h));
        chk({tag, " dayDone"},   32'(dayDone),        32'(d));
        chk({tag, " occupancy"}, 32'(occupancy),      32'(occ));
        chk({tag, " rsHour"},    32'(rushStartHour),  32'(rsh));
        chk({tag, " rsValid"},   32'(rushStartValid), 32'(rsv));
        chk({tag, " reHour"},    32'(rushEndHour),    32'(reh));
        chk({tag, " reValid"},   32'(rushEndValid),   32'(rev));
        chk({tag, " rdData"},    32'(rdData),         32'(rd));
    endtask

    task automatic idle_inputs();
        hourAdvance = 0; carEnter = 0; carExit = 0; rushStart = 0; rushEnd = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cycle(input logic hadv, input logic ent, input logic ext);
        hourAdvance = hadv; carEnter = ent; carExit = ext;
        cyc();
        idle_inputs();
        cyc();
    endtask

    initial begin
        idle_inputs();
        rdAddr = 0;
        reset  = 1;
        #1;
        chk_all("reset_async", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk_all("reset_clocked", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 0;

        //            hadv ent ext rs re addr  h d occ rsh rsv reh rev rd
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 1,  0, 0,  0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 1,  0, 0,  0, 0,  1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 1,  0, 0,  0, 0,  1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 1,  0, 0,  0, 0,  1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 2,  0, 0,  0, 0,  1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 2,  0, 0,  0, 0,  2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 3,  0, 0,  0, 0,  2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 3,  0, 0,  0, 0,  3));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 3,  0, 0,  0, 0,  3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 3,  0, 0,  0, 0,  4));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 3,  0, 0,  0, 0,  4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 2,  0, 0,  0, 0,  5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 2,  0, 0,  0, 0,  5));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 1,  0, 0,  0, 0,  5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 1,  0, 0,  0, 0,  5));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 0,  0, 0,  0, 0,  5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0,  0, 0,  5));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 0,  0, 0,  0, 0,  5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0,  0, 0,  5));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 0,  0, 0,  0, 0,  5));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 1,  0, 0,  0, 0,  5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 1,  0, 0,  0, 0,  6));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0, 1,  0, 0,  0, 0,  6));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 1,  0, 0,  0, 0,  7));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 0, 1,  0, 0,  0, 0,  7));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   1, 0, 1,  1, 1,  0, 0,  7));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   2, 0, 1,  1, 1,  0, 0,  7));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   2, 0, 1,  1, 1,  0, 0,  7));
        vecs.push_back(mk(1, 1, 0, 0, 0, 2,   3, 0, 2,  1, 1,  0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2,   3, 0, 2,  1, 1,  0, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3,   4, 0, 2,  1, 1,  0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2,   4, 0, 2,  1, 1,  4, 1,  1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 2,   5, 0, 2,  1, 1,  4, 1,  1));

        foreach (vecs[i]) begin
            hourAdvance = vecs[i].hadv; carEnter = vecs[i].ent; carExit = vecs[i].ext;
            rushStart = vecs[i].rs; rushEnd = vecs[i].re; rdAddr = vecs[i].addr;
            cyc();
            chk_all($sformatf("vec%0d", i), vecs[i].h, vecs[i].d, vecs[i].occ, vecs[i].rsh,
                    vecs[i].rsv, vecs[i].reh, vecs[i].rev, vecs[i].rd);
        end
        idle_inputs();

        // Mid-day reset between edges: outputs clear without a clock.
        rdAddr = 0;
        cyc();
        #2 reset = 1;
        #1;
        chk_all("midreset_async", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        reset = 0;
        cyc();
        chk_all("after_reset_read0", 0, 0, 0, 0, 0, 0, 0, 0);

        // Entry counter saturation at 15 in hour 0.
        for (int i = 0; i < 16; i++) pulse_cycle(0, 1, 0);
        cyc();
        chk("sat_rd15", 32'(rdData), 32'd15);
        chk("sat_occ3", 32'(occupancy), 32'd3);
        pulse_cycle(0, 1, 0);
        cyc();
        chk("sat_rd_hold15", 32'(rdData), 32'd15);

        // Rush start and end in the same cycle: end is dropped, then captured next time.
        rushStart = 1; rushEnd = 1;
        cyc();
        idle_inputs();
        chk("rush_same_sv", 32'(rushStartValid), 32'd1);
        chk("rush_same_ev", 32'(rushEndValid), 32'd0);
        rushEnd = 1;
        cyc();
        idle_inputs();
        chk("rush_late_ev", 32'(rushEndValid), 32'd1);
        chk("rush_late_eh", 32'(rushEndHour), 32'd0);

        // End of day.
        for (int i = 0; i < 3; i++) pulse_cycle(0, 0, 1);
        chk("day_occ0", 32'(occupancy), 32'd0);
        for (int i = 0; i < 7; i++) pulse_cycle(1, 0, 0);
        chk("day_h7", 32'(hour), 32'd7);
        chk("day_notdone", 32'(dayDone), 32'd0);
        pulse_cycle(1, 0, 0);
        chk("day_done_h7", 32'(hour), 32'd7);
        chk("day_done", 32'(dayDone), 32'd1);
        pulse_cycle(1, 0, 0);
        chk("done_hadv_ignored", 32'(hour), 32'd7);
        chk("done_sticky", 32'(dayDone), 32'd1);
        pulse_cycle(0, 1, 0);
        chk("done_occ1", 32'(occupancy), 32'd1);
        for (int a = 0; a < 8; a++) begin
            rdAddr = 3'(a);
            cyc();
            chk($sformatf("done_entries%0d", a), 32'(rdData), (a == 0) ? 32'd15 : 32'd0);
        end

        // carEnter held high across reset release gives exactly one entry.
        carEnter = 1;
        cyc();
        #2 reset = 1;
        cyc();
        rdAddr = 0;
        reset  = 0;
        cyc();
        chk("held_occ1", 32'(occupancy), 32'd1);
        chk("held_rd_pre", 32'(rdData), 32'd0);
        chk("held_done_cleared", 32'(dayDone), 32'd0);
        cyc();
        chk("held_occ_still1", 32'(occupancy), 32'd1);
        chk("held_rd1", 32'(rdData), 32'd1);
        idle_inputs();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
